fft_output_ctrl: RTL and testbench

//  Unload sequencer for the FFT output stage. After a transform completes it walks the four

---
 rtl/fft_output_ctrl.sv | 117 +++++++++++
 tb/tb_fft_output_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_ctrl.sv
// FFT output-stage unload sequencer: walks the four result banks, steers the 4-lane mixer, flags valid/last/done.
// Build option FFT_OUT_BITREV_EN: read addresses are the bit-reverse of the beat count.
module fft_output_ctrl #(
  parameter int N_POINT  = 256,
  parameter int ADDR_BIT = 6
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iSTART,
  input  logic                iREADY,
  output logic                oRD_EN,
  output logic [ADDR_BIT-1:0] oRD_ADDR,
  output logic [1:0]          oSEL,
  output logic                oVALID,
  output logic                oLAST,
  output logic                oBUSY,
  output logic                oDONE,
  output logic [1:0]          oSTATE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_BIT-1:0] LAST_CNT = ADDR_BIT'(N_POINT / 4 - 1);

  state_t              state;
  logic [ADDR_BIT-1:0] cnt;
  logic                drainCnt;
  logic                rdLast;
  logic                vldD1;
  logic                lastD1;
  logic                issue;

  function automatic logic [ADDR_BIT-1:0] beatAddr(input logic [ADDR_BIT-1:0] c);
    logic [ADDR_BIT-1:0] r;
`ifdef FFT_OUT_BITREV_EN
    for (int i = 0; i < ADDR_BIT; i++) r[i] = c[ADDR_BIT-1-i];
`else
    r = c;
`endif
    return r;
  endfunction

  // Flow control: iREADY is a credit, not a handshake. iREADY=1 promises the sink can
  // absorb at least two more beats, so a beat issued now is always accepted two cycles
  // later; oVALID never waits on iREADY. The cycle right after the last beat issues is
  // blocked so the counter never re-issues before the FSM leaves RUN.
  always_comb begin
    issue = (state == RUN) && iREADY && !(oRD_EN && rdLast);
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state    <= IDLE;
      cnt      <= '0;
      drainCnt <= 1'b0;
      rdLast   <= 1'b0;
      vldD1    <= 1'b0;
      lastD1   <= 1'b0;
      oRD_EN   <= 1'b0;
      oRD_ADDR <= '0;
      oSEL     <= 2'd0;
      oVALID   <= 1'b0;
      oLAST    <= 1'b0;
      oDONE    <= 1'b0;
    end else begin
      oRD_EN <= issue;
      if (issue) begin
        oRD_ADDR <= beatAddr(cnt);
        rdLast   <= (cnt == LAST_CNT);
        if (cnt != LAST_CNT) cnt <= cnt + 1'b1;
      end
      // Sample k sits in bank (k%4 + addr)%4, so the rotation is the address low bits,
      // lined up with the one-cycle RAM read; it holds while no read is in flight.
      if (oRD_EN) oSEL <= oRD_ADDR[1:0];
      vldD1  <= oRD_EN;
      lastD1 <= oRD_EN & rdLast;
      oVALID <= vldD1;
      oLAST  <= lastD1;
      oDONE  <= 1'b0;

      case (state)
        IDLE: begin
          if (iSTART) begin
            state  <= RUN;
            cnt    <= '0;
            rdLast <= 1'b0;
          end
        end
        RUN: begin
          if (oRD_EN && rdLast) begin
            state    <= DRAIN;
            drainCnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drainCnt) begin
            state <= DONE;
            oDONE <= 1'b1;
          end else begin
            drainCnt <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign oBUSY  = (state == RUN) || (state == DRAIN);
  assign oSTATE = state;

endmodule

// File: tb/tb_fft_output_ctrl.sv
// Bench for fft_output_ctrl: cycle table on a 16-point instance, then a bank-RAM + mixer
// scoreboard on a 256-point instance with random sink credit.
module tb_fft_output_ctrl;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16-point instance
  logic       rstA, startA, readyA;
  logic       rdEnA, validA, lastA, busyA, doneA;
  logic [1:0] rdAddrA, selA, stateA;

  fft_output_ctrl #(.N_POINT(16), .ADDR_BIT(2)) dutA (
    .iCLK(clk), .iRESET(rstA), .iSTART(startA), .iREADY(readyA),
    .oRD_EN(rdEnA), .oRD_ADDR(rdAddrA), .oSEL(selA), .oVALID(validA),
    .oLAST(lastA), .oBUSY(busyA), .oDONE(doneA), .oSTATE(stateA)
  );

  // 256-point instance
  logic       rstB, startB, readyB;
  logic       rdEnB, validB, lastB, busyB, doneB;
  logic [5:0] rdAddrB;
  logic [1:0] selB, stateB;

  fft_output_ctrl #(.N_POINT(256), .ADDR_BIT(6)) dutB (
    .iCLK(clk), .iRESET(rstB), .iSTART(startB), .iREADY(readyB),
    .oRD_EN(rdEnB), .oRD_ADDR(rdAddrB), .oSEL(selB), .oVALID(validB),
    .oLAST(lastB), .oBUSY(busyB), .oDONE(doneB), .oSTATE(stateB)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int ea(input int k, input int bits);
    int r;
    r = k;
`ifdef FFT_OUT_BITREV_EN
    r = 0;
    for (int i = 0; i < bits; i++) if (k[i]) r = r | (1 << (bits - 1 - i));
`else
    if (bits < 0) r = 0;
`endif
    return r;
  endfunction

  // table: inputs for one cycle, outputs expected right after the following edge
  typedef struct {
    logic       rst;
    logic       start;
    logic       ready;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rst, input logic start, input logic ready,
                     input logic rdEn, input logic [1:0] addr, input logic [1:0] sel,
                     input logic valid, input logic last, input logic busy, input logic done);
    vec_t v;
    v.rst   = rst;
    v.start = start;
    v.ready = ready;
    v.exp   = {rdEn, addr, sel, valid, last, busy, done};
    vecs.push_back(v);
  endtask

  // bank RAM + mixer model for the 256-point instance
  logic [7:0]  bank [4][64];
  logic [7:0]  ramQ [4];
  logic [7:0]  mix  [4];
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    if (rdEnB) for (int j = 0; j < 4; j++) ramQ[j] <= bank[j][rdAddrB];
    for (int j = 0; j < 4; j++) mix[j] <= ramQ[(j + int'(selB)) % 4];
  end

  logic monOn = 1'b0;
  int   beatIdx = 0;
  int   validCnt = 0;
  bit   doneSeen = 1'b0;

  always @(negedge clk) begin
    if (monOn) begin
      if (rdEnB) begin
        chk("rd_addr_256", 64'(rdAddrB), 64'(ea(beatIdx, 6)));
        beatIdx++;
      end
      if (validB) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 64'(validCnt), 64'd64);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("beat_data", {32'd0, mix[3], mix[2], mix[1], mix[0]}, {32'd0, e});
        end
        chk("last_flag", 64'(lastB), 64'(validCnt == 63));
        validCnt++;
      end
      if (doneB) begin
        doneSeen = 1'b1;
        chk("done_after_last", 64'(validCnt), 64'd64);
      end
    end
  end

  logic [1:0] e0, e1, e2, e3;

  initial begin
    logic [31:0] beat;
    rstA = 1'b0; startA = 1'b0; readyA = 1'b0;
    rstB = 1'b0; startB = 1'b0; readyB = 1'b0;
    e0 = 2'(ea(0, 2)); e1 = 2'(ea(1, 2)); e2 = 2'(ea(2, 2)); e3 = 2'(ea(3, 2));

    // reset, basic run with a mid-RUN start and a start in the oDONE cycle
    add(0,0,0, 0,0,0,0,0,0,0);
    add(1,0,1, 0,0,0,0,0,0,0);
    add(1,1,1, 0,0,0,0,0,1,0);
    add(1,0,1, 1,e0,0,0,0,1,0);
    add(1,1,1, 1,e1,e0,0,0,1,0);
    add(1,0,1, 1,e2,e1,1,0,1,0);
    add(1,0,1, 1,e3,e2,1,0,1,0);
    add(1,0,1, 0,e3,e3,1,0,1,0);
    add(1,0,1, 0,e3,e3,1,1,1,0);
    add(1,0,1, 0,e3,e3,0,0,0,1);
    add(1,1,1, 0,e3,e3,0,0,0,0);
    add(1,0,1, 0,e3,e3,0,0,0,0);
    // three-cycle stall after beat 1
    add(1,1,1, 0,e3,e3,0,0,1,0);
    add(1,0,1, 1,e0,e3,0,0,1,0);
    add(1,0,1, 1,e1,e0,0,0,1,0);
    add(1,0,0, 0,e1,e1,1,0,1,0);
    add(1,0,0, 0,e1,e1,1,0,1,0);
    add(1,0,0, 0,e1,e1,0,0,1,0);
    add(1,0,1, 1,e2,e1,0,0,1,0);
    add(1,0,1, 1,e3,e2,0,0,1,0);
    add(1,0,1, 0,e3,e3,1,0,1,0);
    add(1,0,1, 0,e3,e3,1,1,1,0);
    add(1,0,1, 0,e3,e3,0,0,0,1);
    add(1,0,1, 0,e3,e3,0,0,0,0);
    // reset during beat 2, then a fresh full unload
    add(1,1,1, 0,e3,e3,0,0,1,0);
    add(1,0,1, 1,e0,e3,0,0,1,0);
    add(1,0,1, 1,e1,e0,0,0,1,0);
    add(1,0,1, 1,e2,e1,1,0,1,0);
    add(0,0,1, 0,0,0,0,0,0,0);
    add(1,0,1, 0,0,0,0,0,0,0);
    add(1,0,1, 0,0,0,0,0,0,0);
    add(1,0,1, 0,0,0,0,0,0,0);
    add(1,1,1, 0,0,0,0,0,1,0);
    add(1,0,1, 1,e0,0,0,0,1,0);
    add(1,0,1, 1,e1,e0,0,0,1,0);
    add(1,0,1, 1,e2,e1,1,0,1,0);
    add(1,0,1, 1,e3,e2,1,0,1,0);
    add(1,0,1, 0,e3,e3,1,0,1,0);
    add(1,0,1, 0,e3,e3,1,1,1,0);
    add(1,0,1, 0,e3,e3,0,0,0,1);
    add(1,0,1, 0,e3,e3,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rstA   = vecs[i].rst;
      startA = vecs[i].start;
      readyA = vecs[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          64'({rdEnA, rdAddrA, selA, validA, lastA, busyA, doneA}), 64'(vecs[i].exp));
    end

    // sample 4a'+j stored at address a in bank (j+a)%4, a' = logical beat held at address a
    for (int a = 0; a < 64; a++)
      for (int j = 0; j < 4; j++)
        bank[(j + a) % 4][a] = 8'(4 * ea(a, 6) + j);
    for (int j = 0; j < 4; j++) ramQ[j] = 8'd0;

    @(negedge clk);
    rstB = 1'b1;
    @(negedge clk);
    monOn  = 1'b1;
    startB = 1'b1;
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < 4; j++) beat[8*j +: 8] = 8'(4 * k + j);
      exp_q.push_back(beat);
    end
    @(negedge clk);
    startB = 1'b0;
    for (int c = 0; c < 2000 && !doneSeen; c++) begin
      readyB = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    readyB = 1'b0;
    chk("done_seen_256", 64'(doneSeen), 64'd1);
    chk("beats_issued_256", 64'(beatIdx), 64'd64);
    chk("beats_valid_256", 64'(validCnt), 64'd64);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("idle_after_256", 64'({busyB, rdEnB, validB, doneB}), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
